// File: rtl/fb_pkg.sv
// fb_pkg: shared screen defaults, clear-engine state encoding and the
// address-width helper used by the frame buffer and its RAM.
package fb_pkg;

  localparam int SCREEN_WIDTH  = 270;
  localparam int SCREEN_HEIGHT = 270;
  localparam int PIXEL_W       = 4;

  // Clear-screen engine states. IDLE accepts external writes and clr_start,
  // CLEAR sweeps the whole array, DONE is the one-cycle completion pulse.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_DONE  = 2'd2
  } clr_state_t;

  // Smallest address width that covers a w x h pixel array.
  function automatic int addr_width(input int w, input int h);
    return ((w * h) > 1) ? $clog2(w * h) : 1;
  endfunction

endpackage

// File: rtl/frame_buffer_ctrl_if.sv
// frame_buffer_ctrl_if: pixel write, pixel read and clear-screen signals
// between the drawing/VGA side (master) and the frame buffer (slave).
//
// Handshake semantics: every request (wr_en, rd_en, clr_start) is a
// single-cycle strobe sampled on the rising clock edge; there is no ready
// signal and no backpressure. A write is either committed at that edge or
// discarded with a wr_drop pulse one cycle later. A read always produces
// exactly one rd_valid cycle a fixed number of cycles later. clr_start is
// only honoured while the clear engine is idle; clr_busy/clr_done report it.
interface frame_buffer_ctrl_if
  import fb_pkg::*;
#(
  parameter int X_W    = 9,
  parameter int Y_W    = 9,
  parameter int DATA_W = PIXEL_W
);

  logic              wr_en;
  logic [X_W-1:0]    wr_x;
  logic [Y_W-1:0]    wr_y;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en;
  logic [X_W-1:0]    rd_x;
  logic [Y_W-1:0]    rd_y;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              clr_start;
  logic [DATA_W-1:0] clr_color;
  logic              clr_busy;
  logic              clr_done;
  logic              wr_drop;

  modport master (
    output wr_en, wr_x, wr_y, wr_data,
    output rd_en, rd_x, rd_y,
    output clr_start, clr_color,
    input  rd_data, rd_valid, clr_busy, clr_done, wr_drop
  );

  modport slave (
    input  wr_en, wr_x, wr_y, wr_data,
    input  rd_en, rd_x, rd_y,
    input  clr_start, clr_color,
    output rd_data, rd_valid, clr_busy, clr_done, wr_drop
  );

endinterface

// File: rtl/fb_ram_m9k.sv
// fb_ram_m9k: single-clock simple dual-port pixel RAM. One write port, one
// registered read port, old data returned on a same-address collision.
// The array carries no reset so it maps onto block RAM.
module fb_ram_m9k
  import fb_pkg::*;
#(
  parameter int DATA_W = PIXEL_W,
  parameter int ADDR_W = addr_width(SCREEN_WIDTH, SCREEN_HEIGHT),
  parameter int DEPTH  = SCREEN_WIDTH * SCREEN_HEIGHT
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] q
);

  (* ramstyle = "M9K" *) logic [DATA_W-1:0] mem [DEPTH];

  // Write and registered read share the edge; the nonblocking read of mem
  // sees the pre-write contents, giving old-data read-during-write.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    q <= mem[raddr];
  end

endmodule

// File: rtl/frame_buffer_ctrl.sv
// frame_buffer_ctrl: (x, y) addressed frame buffer with a hardware
// clear-screen engine and a fixed-latency read pipeline (1 or 2 cycles).
module frame_buffer_ctrl
  import fb_pkg::*;
#(
  parameter int WIDTH    = SCREEN_WIDTH,
  parameter int HEIGHT   = SCREEN_HEIGHT,
  parameter int DATA_W   = PIXEL_W,
  parameter int X_W      = 9,
  parameter int Y_W      = 9,
  parameter int ADDR_W   = addr_width(WIDTH, HEIGHT),
  parameter int READ_LAT = 1
) (
  input  logic               clk,
  input  logic               reset,
  frame_buffer_ctrl_if.slave bus,
  output clr_state_t         dbg_state
);

  localparam int                N_PIX     = WIDTH * HEIGHT;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_PIX - 1);
  localparam logic [ADDR_W-1:0] WIDTH_A   = ADDR_W'(WIDTH);
  localparam logic [31:0]       WIDTH_U   = 32'(WIDTH);
  localparam logic [31:0]       HEIGHT_U  = 32'(HEIGHT);

  // Row-major mapping with a constant multiplier; no wrap is applied, the
  // range checks below decide whether the address is used at all.
  function automatic logic [ADDR_W-1:0] xy_to_addr(input logic [X_W-1:0] x,
                                                   input logic [Y_W-1:0] y);
    return (ADDR_W'(y) * WIDTH_A) + ADDR_W'(x);
  endfunction

  clr_state_t        state;
  clr_state_t        state_nxt;
  logic [ADDR_W-1:0] clr_cnt;
  logic [DATA_W-1:0] clr_color_q;

  logic              wr_in_range;
  logic              rd_in_range;
  logic              ext_wr_ok;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] rd_addr;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [DATA_W-1:0] ram_wdata;
  logic [ADDR_W-1:0] ram_raddr;
  logic [DATA_W-1:0] ram_q;

  logic              wr_drop_q;
  logic              rd_v1;
  logic              rd_ok1;
  logic [DATA_W-1:0] rd_data1;

  // Coordinate decode and range checks for both ports.
  assign wr_in_range = (32'(bus.wr_x) < WIDTH_U) && (32'(bus.wr_y) < HEIGHT_U);
  assign rd_in_range = (32'(bus.rd_x) < WIDTH_U) && (32'(bus.rd_y) < HEIGHT_U);
  assign wr_addr     = xy_to_addr(bus.wr_x, bus.wr_y);
  assign rd_addr     = xy_to_addr(bus.rd_x, bus.rd_y);

  // External writes land only while the clear engine is idle; anything else
  // (out of range, or arriving during CLEAR/DONE) is discarded and flagged.
  assign ext_wr_ok = bus.wr_en && (state == ST_IDLE) && wr_in_range;

  // Out-of-range reads fetch address 0 so the RAM is never indexed past its
  // end; their result is forced to zero in the read pipeline anyway.
  assign ram_raddr = rd_in_range ? rd_addr : '0;

  // Clear FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Clear FSM next-state: one full sweep, one DONE cycle, back to IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (bus.clr_start) state_nxt = ST_CLEAR;
      ST_CLEAR: if (clr_cnt == LAST_ADDR) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Sweep counter and fill colour; both are loaded when a clear is accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clr_cnt     <= '0;
      clr_color_q <= '0;
    end else if ((state == ST_IDLE) && bus.clr_start) begin
      clr_cnt     <= '0;
      clr_color_q <= bus.clr_color;
    end else if (state == ST_CLEAR) begin
      clr_cnt <= clr_cnt + ADDR_W'(1);
    end
  end

  // Write-port mux: the clear engine owns the port for the whole sweep.
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = wr_addr;
    ram_wdata = bus.wr_data;
    if (state == ST_CLEAR) begin
      ram_we    = 1'b1;
      ram_waddr = clr_cnt;
      ram_wdata = clr_color_q;
    end else if (ext_wr_ok) begin
      ram_we = 1'b1;
    end
  end

  fb_ram_m9k #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (N_PIX)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (ram_raddr),
    .q     (ram_q)
  );

  // Discarded-write flag, registered so it pulses the cycle after the request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_drop_q <= 1'b0;
    end else begin
      wr_drop_q <= bus.wr_en && !ext_wr_ok;
    end
  end

  // First read stage runs in lockstep with the RAM output register; rd_ok1
  // masks out-of-range results (and stale RAM output) to zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_v1  <= 1'b0;
      rd_ok1 <= 1'b0;
    end else begin
      rd_v1  <= bus.rd_en;
      rd_ok1 <= bus.rd_en && rd_in_range;
    end
  end

  assign rd_data1 = rd_ok1 ? ram_q : '0;

  generate
    if (READ_LAT == 2) begin : g_lat2
      logic              rd_v2;
      logic [DATA_W-1:0] rd_d2;

      // Optional output register for timing closure toward the pixel fetch.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          rd_v2 <= 1'b0;
          rd_d2 <= '0;
        end else begin
          rd_v2 <= rd_v1;
          rd_d2 <= rd_data1;
        end
      end

      assign bus.rd_valid = rd_v2;
      assign bus.rd_data  = rd_d2;
    end else begin : g_lat1
      assign bus.rd_valid = rd_v1;
      assign bus.rd_data  = rd_data1;
    end
  endgenerate

  assign bus.clr_busy = (state == ST_CLEAR);
  assign bus.clr_done = (state == ST_DONE);
  assign bus.wr_drop  = wr_drop_q;
  assign dbg_state    = state;

endmodule

// File: tb/tb_frame_buffer_ctrl.sv
// tb_frame_buffer_ctrl: drives two 8x8 builds (READ_LAT 1 and 2) with the
// same stimulus and checks both against a cycle-scheduled reference model.
module tb_frame_buffer_ctrl;
  import fb_pkg::*;

  localparam int W  = 8;
  localparam int H  = 8;
  localparam int DW = 4;
  localparam int XW = 9;
  localparam int YW = 9;
  localparam int AW = 6;
  localparam int N  = W * H;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- shared stimulus ----------------
  logic          wr_en, rd_en, clr_start;
  logic [XW-1:0] wr_x, rd_x;
  logic [YW-1:0] wr_y, rd_y;
  logic [DW-1:0] wr_data, clr_color;

  frame_buffer_ctrl_if #(.X_W(XW), .Y_W(YW), .DATA_W(DW)) bus1 ();
  frame_buffer_ctrl_if #(.X_W(XW), .Y_W(YW), .DATA_W(DW)) bus2 ();

  assign bus1.wr_en = wr_en;     assign bus2.wr_en = wr_en;
  assign bus1.wr_x = wr_x;       assign bus2.wr_x = wr_x;
  assign bus1.wr_y = wr_y;       assign bus2.wr_y = wr_y;
  assign bus1.wr_data = wr_data; assign bus2.wr_data = wr_data;
  assign bus1.rd_en = rd_en;     assign bus2.rd_en = rd_en;
  assign bus1.rd_x = rd_x;       assign bus2.rd_x = rd_x;
  assign bus1.rd_y = rd_y;       assign bus2.rd_y = rd_y;
  assign bus1.clr_start = clr_start; assign bus2.clr_start = clr_start;
  assign bus1.clr_color = clr_color; assign bus2.clr_color = clr_color;

  clr_state_t dbg1, dbg2;

  frame_buffer_ctrl #(.WIDTH(W), .HEIGHT(H), .DATA_W(DW), .X_W(XW), .Y_W(YW),
                      .ADDR_W(AW), .READ_LAT(1)) dut1 (
    .clk(clk), .reset(rst), .bus(bus1.slave), .dbg_state(dbg1));

  frame_buffer_ctrl #(.WIDTH(W), .HEIGHT(H), .DATA_W(DW), .X_W(XW), .Y_W(YW),
                      .ADDR_W(AW), .READ_LAT(2)) dut2 (
    .clk(clk), .reset(rst), .bus(bus2.slave), .dbg_state(dbg2));

  // ---------------- reference model ----------------
  // Memory image plus a clear schedule expressed in edge numbers: a clear
  // accepted at edge e0 writes pixel a at edge e0+1+a, is busy after edges
  // e0..e0+N-1, signals done after edge e0+N and is idle again from e0+N+1.
  logic [DW-1:0] ref_mem [N];
  bit            ref_known [N];
  bit            clr_on;
  int            clr_e0;
  logic [DW-1:0] clr_col;
  int            e;
  bit            exp_drop;

  typedef struct {
    int            due;
    logic [DW-1:0] data;
    bit            known;
  } rd_exp_t;

  rd_exp_t exp_q1[$];
  rd_exp_t exp_q2[$];

  int errors = 0;
  int checks = 0;
  int busy_cnt, done_cnt;

  function automatic bit in_rng(input int x, input int y);
    return (x < W) && (y < H);
  endfunction

  function automatic bit edge_clears(input int en);
    return clr_on && (en >= clr_e0 + 1) && (en <= clr_e0 + N);
  endfunction

  function automatic bit edge_is_done(input int en);
    return clr_on && (en == clr_e0 + N + 1);
  endfunction

  function automatic bit edge_idle(input int en);
    return !clr_on || (en >= clr_e0 + N + 2);
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    bit      busy_e, done_e, v;
    rd_exp_t r;
    busy_e = clr_on && (e >= clr_e0) && (e <= clr_e0 + N - 1);
    done_e = clr_on && (e == clr_e0 + N);
    check("clr_busy_l1", 32'(bus1.clr_busy), 32'(busy_e));
    check("clr_busy_l2", 32'(bus2.clr_busy), 32'(busy_e));
    check("clr_done_l1", 32'(bus1.clr_done), 32'(done_e));
    check("clr_done_l2", 32'(bus2.clr_done), 32'(done_e));
    check("wr_drop_l1", 32'(bus1.wr_drop), 32'(exp_drop));
    check("wr_drop_l2", 32'(bus2.wr_drop), 32'(exp_drop));
    v = (exp_q1.size() > 0) && (exp_q1[0].due == e);
    check("rd_valid_l1", 32'(bus1.rd_valid), 32'(v));
    if (v) begin
      r = exp_q1.pop_front();
      if (r.known) check("rd_data_l1", 32'(bus1.rd_data), 32'(r.data));
    end
    v = (exp_q2.size() > 0) && (exp_q2[0].due == e);
    check("rd_valid_l2", 32'(bus2.rd_valid), 32'(v));
    if (v) begin
      r = exp_q2.pop_front();
      if (r.known) check("rd_data_l2", 32'(bus2.rd_data), 32'(r.data));
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    wr_en = 1'b0; rd_en = 1'b0; clr_start = 1'b0;
    wr_x = '0; wr_y = '0; wr_data = '0;
    rd_x = '0; rd_y = '0; clr_color = '0;
  endtask

  // Apply the current inputs for one edge: update the model, step the clock,
  // check outputs at the following falling edge.
  task automatic tick();
    int      en, a;
    bit      acc;
    rd_exp_t r;
    en = e + 1;
    if (rd_en) begin
      if (in_rng(int'(rd_x), int'(rd_y))) begin
        a = int'(rd_y) * W + int'(rd_x);
        r.data = ref_mem[a]; r.known = ref_known[a];
      end else begin
        r.data = '0; r.known = 1'b1;
      end
      r.due = en;     exp_q1.push_back(r);
      r.due = en + 1; exp_q2.push_back(r);
    end
    if (edge_clears(en)) begin
      a = en - clr_e0 - 1;
      ref_mem[a] = clr_col; ref_known[a] = 1'b1;
    end
    acc = wr_en && edge_idle(en) && in_rng(int'(wr_x), int'(wr_y));
    if (acc) begin
      a = int'(wr_y) * W + int'(wr_x);
      ref_mem[a] = wr_data; ref_known[a] = 1'b1;
    end
    exp_drop = wr_en && !acc;
    if (clr_start && edge_idle(en)) begin
      clr_on = 1'b1; clr_e0 = en; clr_col = clr_color;
    end
    @(posedge clk);
    e = en;
    @(negedge clk);
    check_outputs();
  endtask

  task automatic do_write(input int x, input int y, input logic [DW-1:0] d);
    wr_en = 1'b1; wr_x = XW'(x); wr_y = YW'(y); wr_data = d;
  endtask

  task automatic do_read(input int x, input int y);
    rd_en = 1'b1; rd_x = XW'(x); rd_y = YW'(y);
  endtask

  // Start a clear and run until well past its end, counting busy/done cycles.
  task automatic run_clear(input logic [DW-1:0] col, input int extra_ticks);
    busy_cnt = 0; done_cnt = 0;
    idle_inputs();
    clr_start = 1'b1; clr_color = col;
    tick();
    if (bus1.clr_busy) busy_cnt++;
    if (bus1.clr_done) done_cnt++;
    idle_inputs();
    for (int i = 0; i < extra_ticks; i++) begin
      tick();
      if (bus1.clr_busy) busy_cnt++;
      if (bus1.clr_done) done_cnt++;
    end
  endtask

  task automatic read_all();
    for (int i = 0; i < N; i++) begin
      idle_inputs();
      do_read(i % W, i / W);
      tick();
    end
    idle_inputs();
    repeat (3) tick();
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    idle_inputs();
    for (int i = 0; i < N; i++) begin
      ref_known[i] = 1'b0; ref_mem[i] = '0;
    end
    clr_on = 1'b0; clr_e0 = 0; clr_col = '0; e = 0; exp_drop = 1'b0;

    // Reset values
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_rd_valid_l1", 32'(bus1.rd_valid), 32'd0);
    check("reset_rd_valid_l2", 32'(bus2.rd_valid), 32'd0);
    check("reset_rd_data_l2", 32'(bus2.rd_data), 32'd0);
    check("reset_clr_busy", 32'(bus1.clr_busy), 32'd0);
    check("reset_wr_drop", 32'(bus1.wr_drop), 32'd0);
    check("reset_state", 32'(dbg1), 32'(ST_IDLE));
    rst = 1'b0;

    // Write (5,7)=A, read it back the next cycle
    do_write(5, 7, 4'hA); tick();
    idle_inputs(); do_read(5, 7); tick();
    idle_inputs(); repeat (3) tick();

    // Out-of-range writes and read
    do_write(270, 0, 4'h6); tick();
    idle_inputs(); do_write(0, 300, 4'h7); tick();
    idle_inputs(); do_read(270, 0); tick();
    idle_inputs(); do_read(5, 7); tick();
    idle_inputs(); repeat (3) tick();

    // Full clear with colour 3
    run_clear(4'h3, N + 5);
    check("clear_busy_cycles", 32'(busy_cnt), 32'(N));
    check("clear_done_pulses", 32'(done_cnt), 32'd1);
    read_all();

    // Write and second clr_start during a clear
    busy_cnt = 0; done_cnt = 0;
    idle_inputs(); clr_start = 1'b1; clr_color = 4'h5; tick();
    if (bus1.clr_done) done_cnt++;
    idle_inputs();
    repeat (5) begin tick(); if (bus1.clr_done) done_cnt++; end
    do_write(1, 1, 4'h9); clr_start = 1'b1; clr_color = 4'hE; tick();
    check("drop_during_clear", 32'(bus1.wr_drop), 32'd1);
    if (bus1.clr_done) done_cnt++;
    idle_inputs();
    for (int i = 0; i < N + 5; i++) begin
      tick();
      if (bus1.clr_done) done_cnt++;
    end
    check("single_done_pulse", 32'(done_cnt), 32'd1);
    do_read(1, 1); tick();
    idle_inputs(); repeat (3) tick();

    // Same-cycle read/write to (2,2): old data first, new data next cycle
    do_write(2, 2, 4'h1); tick();
    idle_inputs(); do_write(2, 2, 4'hF); do_read(2, 2); tick();
    idle_inputs(); do_read(2, 2); tick();
    idle_inputs(); repeat (3) tick();

    // Reset while the clear counter is at 20, with reads in flight
    idle_inputs(); clr_start = 1'b1; clr_color = 4'h7; tick();
    idle_inputs();
    for (int i = 0; i < 20; i++) begin
      do_read(i % W, i / W);
      tick();
    end
    idle_inputs();
    #2 rst = 1'b1;
    #1;
    check("midclr_rst_busy_l1", 32'(bus1.clr_busy), 32'd0);
    check("midclr_rst_busy_l2", 32'(bus2.clr_busy), 32'd0);
    check("midclr_rst_done", 32'(bus1.clr_done), 32'd0);
    check("midclr_rst_valid_l1", 32'(bus1.rd_valid), 32'd0);
    check("midclr_rst_valid_l2", 32'(bus2.rd_valid), 32'd0);
    check("midclr_rst_data_l1", 32'(bus1.rd_data), 32'd0);
    check("midclr_rst_data_l2", 32'(bus2.rd_data), 32'd0);
    clr_on = 1'b0; exp_drop = 1'b0;
    exp_q1.delete(); exp_q2.delete();
    repeat (2) @(posedge clk);
    e = e + 2;
    @(negedge clk);
    rst = 1'b0;
    check("post_rst_state_l1", 32'(dbg1), 32'(ST_IDLE));
    repeat (4) tick();
    check("post_rst_state_l2", 32'(dbg2), 32'(ST_IDLE));
    run_clear(4'hC, N + 5);
    check("reclear_busy_cycles", 32'(busy_cnt), 32'(N));
    check("reclear_done_pulses", 32'(done_cnt), 32'd1);
    read_all();

    // Randomized traffic, including occasional clears
    for (int i = 0; i < 400; i++) begin
      idle_inputs();
      wr_en     = 1'($urandom_range(0, 1));
      wr_x      = XW'($urandom_range(0, W + 2));
      wr_y      = YW'($urandom_range(0, H + 2));
      wr_data   = DW'($urandom_range(0, 15));
      rd_en     = 1'($urandom_range(0, 1));
      rd_x      = XW'($urandom_range(0, W + 2));
      rd_y      = YW'($urandom_range(0, H + 2));
      clr_start = ($urandom_range(0, 79) == 0);
      clr_color = DW'($urandom_range(0, 15));
      if (edge_is_done(e + 1)) wr_en = 1'b0;
      tick();
    end
    idle_inputs();
    repeat (N + 5) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
